riscv_fetch_unit: RTL and testbench

Parametrised instruction fetch front-end for the next-generation RISC-V core. It replaces the single-cycle PC register and combinational instruction ROM with a PC generator, a request/grant/response instruction-memory interface tolerating wait states, and a prefetch FIFO. It sits between instruction memory and the main decoder. Taken branch/jal/jalr targets arrive from the execute stage as redirects.

---
 rtl/riscv_fetch_unit_pkg.sv | 14 +
 rtl/riscv_fetch_unit_if.sv | 34 +++
 rtl/riscv_fetch_unit_fifo.sv | 61 ++++++
 rtl/riscv_fetch_unit.sv | 126 ++++++++++++
 tb/tb_riscv_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_fetch_unit_pkg.sv
// riscv_pkg: constants and the fetch entry type shared by the fetch path.
// No ports; imported by the interface, the FIFO and the fetch unit.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// riscv_fetch_unit_if: instruction-memory and decoder-side handshakes.
// master = fetch unit (drives req/addr and the decoder head),
// slave = environment (memory grant/response and decoder ready).
interface riscv_fetch_unit_if
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
);

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [ILEN-1:0] imem_rdata_i;
    logic            instr_valid_o;
    logic [ILEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_valid_o, instr_o, instr_pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_valid_o, instr_o, instr_pc_o,
        output instr_ready_i
    );

endinterface

// File: rtl/riscv_fetch_unit_fifo.sv
// riscv_sync_fifo: synchronous FIFO with flush, occupancy count and flags.
// Ports: clk, reset, flush, push/wdata, pop/rdata, count, full, empty.
module riscv_sync_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is read straight from storage: no input-to-output path.
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push)
                           - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: PC generator, credit-limited imem requests, prefetch FIFO.
// Ports: clk, reset, bus (imem req/gnt/rvalid + decoder head), redirect_i/_pc_i, misaligned_o.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(riscv_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               reset,
    riscv_fetch_unit_if.master bus,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               misaligned_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ILEN + XLEN;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   entry_count;
    logic [CW-1:0]   tag_count;
    logic [CW:0]     credits_used;
    logic            entry_full;
    logic            entry_empty;
    logic            tag_full;
    logic            tag_empty;
    logic [XLEN-1:0] tag_pc;
    logic [EW-1:0]   head;
    logic            grant;
    logic            take;
    logic            pop;

    // In-flight plus buffered words may never exceed the FIFO size,
    // so every accepted response is guaranteed a free slot.
    assign credits_used   = {1'b0, outstanding} + {1'b0, entry_count};
    assign bus.imem_req_o = !reset && !redirect_i
                         && credits_used < (CW+1)'(FIFO_DEPTH);
    assign bus.imem_addr_o = fetch_pc;
    assign grant = bus.imem_req_o && bus.imem_gnt_i;

    // A response is kept only once all pre-redirect words are dropped.
    assign take = bus.imem_rvalid_i && !redirect_i && discard == '0;

    assign bus.instr_valid_o = !entry_empty && !redirect_i;
    assign pop          = bus.instr_valid_o && bus.instr_ready_i;
    assign bus.instr_o    = head[EW-1:XLEN];
    assign bus.instr_pc_o = head[XLEN-1:0];

    riscv_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_i),
        .push  (grant),
        .wdata (fetch_pc),
        .pop   (take),
        .rdata (tag_pc),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    riscv_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_entry_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_i),
        .push  (take),
        .wdata ({bus.imem_rdata_i, tag_pc}),
        .pop   (pop),
        .rdata (head),
        .count (entry_count),
        .full  (entry_full),
        .empty (entry_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            outstanding  <= '0;
            discard      <= '0;
            misaligned_o <= 1'b0;
        end else begin
            misaligned_o <= redirect_i && (|redirect_pc_i[1:0]);
            outstanding  <= outstanding + CW'(grant)
                          - CW'(bus.imem_rvalid_i);
            if (redirect_i) begin
                fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
                // A word returning this cycle is already dropped.
                discard  <= outstanding - CW'(bus.imem_rvalid_i);
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (bus.imem_rvalid_i && discard != '0) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    a_push_full: assert property (
        @(posedge clk) disable iff (reset)
        !(take && entry_full && !pop));

    a_tag_room: assert property (
        @(posedge clk) disable iff (reset)
        !(grant && tag_full));

    a_tag_live: assert property (
        @(posedge clk) disable iff (reset)
        !(take && tag_empty));

    a_tag_count: assert property (
        @(posedge clk) disable iff (reset)
        tag_count <= outstanding);

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed scenarios against a latency-programmable
// memory model; decoder output checked by a scoreboard monitor.
module tb_riscv_fetch_unit;
    import riscv_pkg::*;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        misaligned_o;
    logic        gnt_en;
    int          lat;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          grants;

    mem_req_t     mq[$];
    fetch_entry_t exp_q[$];

    riscv_fetch_unit_if #(.XLEN(32)) bus ();

    riscv_fetch_unit #(
        .XLEN       (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk = ~clk;

    assign bus.imem_gnt_i = gnt_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory: in-order responses, lat cycles after the grant cycle.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            bus.imem_rvalid_i <= 1'b0;
            bus.imem_rdata_i  <= '0;
        end else begin
            if (bus.imem_req_o && bus.imem_gnt_i)
                mq.push_back('{cyc + lat, bus.imem_addr_o});
            bus.imem_rvalid_i <= 1'b0;
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                bus.imem_rvalid_i <= 1'b1;
                bus.imem_rdata_i  <= mem_word(mq[0].addr);
                mq.delete(0);
            end
        end
        cyc++;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin : mon
        fetch_entry_t e;
        if (!reset && bus.instr_valid_o && bus.instr_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: pc=%h instr=%h, required no output",
                         bus.instr_pc_o, bus.instr_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.instr_pc_o !== e.pc || bus.instr_o !== e.instr) begin
                    errors++;
                    $display("FAIL sb_entry: pc=%h instr=%h, required pc=%h instr=%h",
                             bus.instr_pc_o, bus.instr_o, e.pc, e.instr);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // Leaves the bench 2 time units into cycle 0 after release.
    task automatic do_reset();
        reset      = 1'b1;
        redirect_i = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (exp_q.size() != 0 && n < 60);
        #2 bus.instr_ready_i = 1'b0;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        reset             = 1'b1;
        redirect_i        = 1'b0;
        redirect_pc_i     = '0;
        gnt_en            = 1'b1;
        lat               = 1;
        bus.instr_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req", bus.imem_req_o, 0);
        check("rst_valid", bus.instr_valid_o, 0);
        check("rst_instr", bus.instr_o, 0);
        check("rst_pc", bus.instr_pc_o, 0);
        check("rst_misaligned", misaligned_o, 0);

        // Zero-wait streaming.
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("s1_req", bus.imem_req_o, 1);
                check("s1_addr", bus.imem_addr_o, 32'h0);
            end
            check($sformatf("s1_valid_c%0d", c), bus.instr_valid_o, c >= 2);
        end
        drain("s1_drain");

        // Decoder stalled: credit limit.
        do_reset();
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.imem_req_o && bus.imem_gnt_i) grants++;
        end
        check("s2_grants", grants, 4);
        check("s2_req_idle", bus.imem_req_o, 0);
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        tick();
        bus.instr_ready_i = 1'b1;
        drain("s2_drain");

        // Redirect with two requests in flight, 3-cycle memory.
        lat = 3;
        do_reset();
        bus.instr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(32'h100 + 32'(i * 4));
        tick();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        @(negedge clk);
        check("s3_req_redirect", bus.imem_req_o, 0);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        check("s3_discard", dut.discard, 2);
        check("s3_req", bus.imem_req_o, 1);
        check("s3_addr", bus.imem_addr_o, 32'h100);
        drain("s3_drain");

        // Redirect in the same cycle as a response.
        do_reset();
        bus.instr_ready_i = 1'b1;
        expect_pc(32'h200);
        expect_pc(32'h204);
        tick();
        tick();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        check("s4_discard", dut.discard, 2);
        drain("s4_drain");

        // Misaligned redirect target.
        lat = 1;
        do_reset();
        bus.instr_ready_i = 1'b1;
        expect_pc(32'h0);
        expect_pc(32'h100);
        expect_pc(32'h104);
        expect_pc(32'h108);
        tick();
        tick();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        @(negedge clk);
        check("s5_valid_forced", bus.instr_valid_o, 0);
        check("s5_mis_early", misaligned_o, 0);
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        check("s5_mis_pulse", misaligned_o, 1);
        check("s5_req", bus.imem_req_o, 1);
        check("s5_addr", bus.imem_addr_o, 32'h100);
        tick();
        @(negedge clk);
        check("s5_mis_clear", misaligned_o, 0);
        drain("s5_drain");

        // PC wrap, then asynchronous reset mid-burst.
        do_reset();
        bus.instr_ready_i = 1'b1;
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        check("s6_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("s6_addr_wrap", bus.imem_addr_o, 32'h0);
        drain("s6_drain");
        tick();
        tick();
        @(posedge clk);
        #3;
        check("s6_pre_valid", bus.instr_valid_o, 1);
        reset = 1'b1;
        #1;
        check("s6_async_valid", bus.instr_valid_o, 0);
        check("s6_async_instr", bus.instr_o, 0);
        check("s6_async_pc", bus.instr_pc_o, 0);
        check("s6_async_req", bus.imem_req_o, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        bus.instr_ready_i = 1'b1;
        expect_pc(32'h0);
        expect_pc(32'h4);
        @(negedge clk);
        check("s6_restart_req", bus.imem_req_o, 1);
        check("s6_restart_addr", bus.imem_addr_o, 32'h0);
        drain("s6_restart_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
